// File: rtl/prefetch_issue_queue.sv
// prefetch_issue_queue
//   Small FIFO of predicted prefetch line addresses feeding a single
//   outstanding-prefetch issue slot (IDLE/WAIT handshake with memory).
//   Optional build macro: PF_DEDUP_EN drops requests whose line already
//   sits in the queue or in the in-flight issue register.
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   prefetch_en   : request valid, ORB is the predicted byte address
//   demand_busy   : demand miss owns memory, hold off new issues
//   flush         : discard all queued (not yet issued) requests
//   pf_read       : prefetch read, held until pf_resp
//   pf_address    : line-aligned address of the in-flight prefetch
//   pf_resp       : memory completes the in-flight prefetch
//   count, full   : queue occupancy / occupancy == DEPTH
//   drop          : combinational, current request is discarded
module prefetch_issue_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prefetch_en,
  input  logic [31:0]              ORB,
  input  logic                     demand_busy,
  input  logic                     flush,
  output logic                     pf_read,
  output logic [31:0]              pf_address,
  input  logic                     pf_resp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = 27;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]   issue_q;
  logic [LW-1:0]   mem_q [DEPTH];

  logic            full_c, pop_c, enq_c, dup_c;
  logic [LW-1:0]   line_c;
  logic            unused_orb_c;

  assign line_c       = ORB[31:5];
  assign unused_orb_c = ^ORB[4:0];

  // Queue control; full is judged on the pre-edge count so a same-cycle pop
  // never rescues an enqueue into a full queue.
  always_comb begin
    full_c = (count_q == CW'(DEPTH));
    pop_c  = (state_q == IDLE) && (count_q != '0) && !demand_busy && !flush && !rst;
    enq_c  = prefetch_en && !flush && !rst && !full_c && !dup_c;
    drop   = prefetch_en && !flush && !rst && !enq_c;
  end

`ifdef PF_DEDUP_EN
  // Match against occupied slots (offset from head below count) and the
  // in-flight line.
  always_comb begin
    logic [PW-1:0] off;
    dup_c = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ((CW'(off) < count_q) && (mem_q[i] == line_c)) dup_c = 1'b1;
    end
    if ((state_q == WAIT) && (issue_q == line_c)) dup_c = 1'b1;
  end
`else
  assign dup_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; demand_busy and flush never abort WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pop_c)   state_d = WAIT;
      WAIT: if (pf_resp) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    pf_read    = 1'b0;
    pf_address = '0;
    if (state_q == WAIT) begin
      pf_read    = 1'b1;
      pf_address = {issue_q, 5'b0};
    end
  end

  assign count = count_q;
  assign full  = full_c;

  // Pointers, occupancy and issue register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      issue_q  <= '0;
    end else begin
      if (pop_c) issue_q <= mem_q[rd_ptr_q];
      if (flush) begin
        count_q  <= '0;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        count_q <= count_q + CW'(enq_c) - CW'(pop_c);
        if (enq_c) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (enq_c) mem_q[wr_ptr_q] <= line_c;
  end

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Bench for prefetch_issue_queue: directed table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_prefetch_issue_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prefetch_en = 1'b0;
  logic [31:0] ORB = '0;
  logic        demand_busy = 1'b0;
  logic        flush = 1'b0;
  logic        pf_read;
  logic [31:0] pf_address;
  logic        pf_resp = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        drop;

  prefetch_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .prefetch_en(prefetch_en), .ORB(ORB),
    .demand_busy(demand_busy), .flush(flush), .pf_read(pf_read),
    .pf_address(pf_address), .pf_resp(pf_resp), .count(count),
    .full(full), .drop(drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: plain queue of line addresses plus one in-flight slot.
  logic [26:0] mq[$];
  bit          m_wait = 1'b0;
  logic [26:0] m_issue = '0;

  // Values sampled in the most recent step.
  logic        s_read, s_full, s_drop;
  logic [31:0] s_addr;
  logic [2:0]  s_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, sample and compare against the model, advance model.
  task automatic step(input logic pe, input logic [31:0] orb, input logic db,
                      input logic fl, input logic resp, input logic r);
    bit dup, acc, pop;
    @(negedge clk);
    prefetch_en = pe; ORB = orb; demand_busy = db; flush = fl; pf_resp = resp; rst = r;
    #1;
    s_read = pf_read; s_addr = pf_address; s_count = count; s_full = full; s_drop = drop;
    dup = 1'b0;
`ifdef PF_DEDUP_EN
    foreach (mq[i]) if (mq[i] == orb[31:5]) dup = 1'b1;
    if (m_wait && m_issue == orb[31:5]) dup = 1'b1;
`endif
    acc = pe && !fl && !r && (mq.size() < DEPTH) && !dup;
    chk("model_pf_read", 32'(pf_read), 32'(m_wait));
    chk("model_pf_address", pf_address, m_wait ? {m_issue, 5'b0} : 32'h0);
    chk("model_count", 32'(count), 32'(mq.size()));
    chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("model_drop", 32'(drop), 32'(pe && !fl && !r && !acc));
    if (r) begin
      mq.delete(); m_wait = 1'b0; m_issue = '0;
    end else begin
      pop = !m_wait && (mq.size() > 0) && !db && !fl;
      if (m_wait) begin
        if (resp) m_wait = 1'b0;
      end else if (pop) begin
        m_issue = mq.pop_front();
        m_wait  = 1'b1;
      end
      if (fl) mq.delete();
      if (acc) mq.push_back(orb[31:5]);
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        pe;
    logic [31:0] orb;
    logic        db, fl, resp;
    logic        e_read;
    logic [31:0] e_addr;
    logic [2:0]  e_count;
    logic        e_full, e_drop;
  } vec_t;

  vec_t vt[12];
  logic [31:0] issued[$];
  logic [31:0] exp_order[4];
  logic        prev_read;

  initial begin
    // Directed single-request flow, expectations observed before each edge.
    vt[0]  = '{1, 32'h0000_1234, 0, 0, 0, 0, 32'h0,     3'd0, 0, 0};
    vt[1]  = '{0, 32'h0,         0, 0, 0, 0, 32'h0,     3'd1, 0, 0};
    vt[2]  = '{0, 32'h0,         0, 0, 0, 1, 32'h1220,  3'd0, 0, 0};
    vt[3]  = '{0, 32'h0,         0, 0, 1, 1, 32'h1220,  3'd0, 0, 0};
    vt[4]  = '{0, 32'h0,         0, 0, 0, 0, 32'h0,     3'd0, 0, 0};
    vt[5]  = '{1, 32'h0000_1234, 0, 1, 0, 0, 32'h0,     3'd0, 0, 0};
    vt[6]  = '{0, 32'h0,         0, 0, 1, 0, 32'h0,     3'd0, 0, 0};
    vt[7]  = '{1, 32'h0000_0ABC, 1, 0, 0, 0, 32'h0,     3'd0, 0, 0};
    vt[8]  = '{0, 32'h0,         1, 0, 0, 0, 32'h0,     3'd1, 0, 0};
    vt[9]  = '{0, 32'h0,         0, 0, 0, 0, 32'h0,     3'd1, 0, 0};
    vt[10] = '{0, 32'h0,         0, 0, 1, 1, 32'h0AA0,  3'd0, 0, 0};
    vt[11] = '{0, 32'h0,         0, 0, 0, 0, 32'h0,     3'd0, 0, 0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(vt[i].pe, vt[i].orb, vt[i].db, vt[i].fl, vt[i].resp, 0);
      chk($sformatf("vec%0d_pf_read", i), 32'(s_read), 32'(vt[i].e_read));
      chk($sformatf("vec%0d_pf_address", i), s_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_count", i), 32'(s_count), 32'(vt[i].e_count));
      chk($sformatf("vec%0d_full", i), 32'(s_full), 32'(vt[i].e_full));
      chk($sformatf("vec%0d_drop", i), 32'(s_drop), 32'(vt[i].e_drop));
    end

    // Overflow under demand_busy, then in-order drain.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1, 32'(i) << 8, 1, 0, 0, 0);
      if (i == 5) chk("ovf_drop_5th", 32'(s_drop), 32'd1);
    end
    step(0, 0, 1, 0, 0, 0);
    chk("ovf_full", 32'(s_full), 32'd1);
    chk("ovf_count", 32'(s_count), 32'd4);
    exp_order = '{32'h100, 32'h200, 32'h300, 32'h400};
    prev_read = 1'b0;
    for (int c = 0; c < 40 && issued.size() < 4; c++) begin
      step(0, 0, 0, 0, s_read, 0);
      if (s_read && !prev_read) issued.push_back(s_addr);
      prev_read = s_read;
    end
    chk("ovf_issue_cnt", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_issue%0d", i), (i < issued.size()) ? issued[i] : 32'hDEAD, exp_order[i]);

    // Duplicate line handling.
    do_reset();
    step(1, 32'h1000, 1, 0, 0, 0);
    step(1, 32'h101C, 1, 0, 0, 0);
`ifdef PF_DEDUP_EN
    chk("dedup_drop", 32'(s_drop), 32'd1);
    step(0, 0, 1, 0, 0, 0);
    chk("dedup_count", 32'(s_count), 32'd1);
`else
    chk("dedup_drop", 32'(s_drop), 32'd0);
    step(0, 0, 1, 0, 0, 0);
    chk("dedup_count", 32'(s_count), 32'd2);
`endif

    // Flush with a transaction in flight.
    do_reset();
    step(1, 32'h2000, 0, 0, 0, 0);
    step(1, 32'h3000, 0, 0, 0, 0);
    step(1, 32'h4000, 0, 0, 0, 0);
    step(1, 32'h5000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("flush_pre_count", 32'(s_count), 32'd3);
    chk("flush_pre_addr", s_addr, 32'h2000);
    step(1, 32'h6000, 0, 1, 0, 0);
    chk("flush_drop", 32'(s_drop), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("flush_count", 32'(s_count), 32'd0);
      chk("flush_read_held", 32'(s_read), 32'd1);
    end
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("flush_no_issue", 32'(s_read), 32'd0);
    end

    // Reset during WAIT, then a stale response.
    do_reset();
    step(1, 32'h7000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rstw_in_wait", 32'(s_read), 32'd1);
    step(1, 32'h8000, 0, 0, 0, 1);
    chk("rstw_drop", 32'(s_drop), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("rstw_read", 32'(s_read), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rstw_stale_read", 32'(s_read), 32'd0);
    chk("rstw_stale_count", 32'(s_count), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) << 5) | ($urandom & 32'h1F),
           ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
           ($urandom_range(0, 999) < 8) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
